// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative RV32M multiply/divide unit for the EX stage.
//
// A multiply uses a radix-2 shift-add over the operand magnitudes, one bit per
// cycle for 32 cycles. A divide uses restoring division, one quotient bit per
// cycle. Result signs are applied when the result is formatted.
//
// Special divides (B=0, and signed overflow 0x80000000 / -1) are resolved when
// the request is accepted. They go straight to FIN.
//
// Optional build macro: MDU_FAST_MUL_EN. When it is defined, MUL* ops form the
// 64-bit product combinationally in a single MUL cycle (IDLE->MUL->FIN).
// Divides are unchanged in both builds.
//
// Ports:
//   clk    in  1      rising-edge clock
//   rstn   in  1      asynchronous active-low reset
//   start  in  1      request pulse, sampled only in IDLE
//   op     in  3      RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   A      in  WIDTH  rs1 operand
//   B      in  WIDTH  rs2 operand
//   flush  in  1      abort the current operation
//   busy   out 1      high while an accepted operation is in MUL/DIV/FIN
//   done   out 1      one-cycle pulse; C is valid that cycle
//   C      out WIDTH  result; held after done until the next completion
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [2:0]         op_reg, op_next;
  logic [WIDTH-1:0]   ma_reg, ma_next;      // magnitude of A
  logic [WIDTH-1:0]   mb_reg, mb_next;      // magnitude of B
  logic               neg_reg, neg_next;    // product / quotient sign
  logic               sa_reg, sa_next;      // remainder sign (follows A)
  logic [CW-1:0]      cnt_reg, cnt_next;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
  logic [2*WIDTH-1:0] p_reg, p_next;
  logic [WIDTH-1:0]   res_reg, res_next;    // result presented during FIN
  logic [WIDTH-1:0]   c_reg;                // last committed result

  // Sign-correct the raw magnitude result and pick the word the op asks for.
  function automatic logic [WIDTH-1:0] format_result(
    input logic [2*WIDTH-1:0] p,
    input logic [2:0]         o,
    input logic               neg,
    input logic               sa
  );
    logic [2*WIDTH-1:0] full;
    logic [WIDTH-1:0]   q, r;
    full = neg ? (~p + 1'b1) : p;
    q    = p[WIDTH-1:0];
    r    = p[2*WIDTH-1:WIDTH];
    if (!o[2]) begin
      format_result = (o[1:0] == 2'b00) ? full[WIDTH-1:0] : full[2*WIDTH-1:WIDTH];
    end else if (!o[1]) begin
      format_result = neg ? (~q + 1'b1) : q;
    end else begin
      format_result = sa ? (~r + 1'b1) : r;
    end
  endfunction

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    ma_next    = ma_reg;
    mb_next    = mb_reg;
    neg_next   = neg_reg;
    sa_next    = sa_reg;
    cnt_next   = cnt_reg;
    p_next     = p_reg;
    res_next   = res_reg;
    add_sum    = '0;
    div_shift  = '0;
    div_diff   = '0;

    // MULH, MULHSU, DIV and REM treat A as signed; MULH, DIV and REM treat B as signed.
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && A[WIDTH-1];
    b_neg    = b_signed && B[WIDTH-1];
    a_mag    = a_neg ? (~A + 1'b1) : A;
    b_mag    = b_neg ? (~B + 1'b1) : B;

    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          op_next  = op;
          ma_next  = a_mag;
          mb_next  = b_mag;
          neg_next = a_neg ^ b_neg;
          sa_next  = a_neg;
          cnt_next = '0;
          if (op[2] && (B == '0)) begin
            res_next   = op[1] ? A : ALL_ONES;
            state_next = FIN;
          end else if (op[2] && !op[0] && (A == MIN_NEG) && (B == ALL_ONES)) begin
            res_next   = op[1] ? '0 : MIN_NEG;
            state_next = FIN;
          end else if (op[2]) begin
            p_next     = {{WIDTH{1'b0}}, a_mag};
            state_next = DIV;
          end else begin
            p_next     = {{WIDTH{1'b0}}, b_mag};
            state_next = MUL;
          end
        end
      end

      MUL: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
`ifdef MDU_FAST_MUL_EN
          p_next     = {{WIDTH{1'b0}}, ma_reg} * {{WIDTH{1'b0}}, mb_reg};
          res_next   = format_result(p_next, op_reg, neg_reg, sa_reg);
          state_next = FIN;
`else
          // Add the multiplicand into the high half when the current multiplier
          // bit is set, then shift right. The carry re-enters at the top.
          add_sum = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, ma_reg} : '0);
          p_next  = {add_sum, p_reg[WIDTH-1:1]};
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            res_next   = format_result(p_next, op_reg, neg_reg, sa_reg);
            state_next = FIN;
          end
`endif
        end
      end

      DIV: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          // Shift the next dividend bit into the remainder. Subtract only if the
          // result stays non-negative.
          div_shift = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]};
          div_diff  = div_shift - {1'b0, mb_reg};
          if (div_shift >= {1'b0, mb_reg}) begin
            p_next = {div_diff[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b1};
          end else begin
            p_next = {div_shift[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b0};
          end
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            res_next   = format_result(p_next, op_reg, neg_reg, sa_reg);
            state_next = FIN;
          end
        end
      end

      FIN: begin
        // A start during FIN is ignored; IDLE is always next.
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      ma_reg    <= '0;
      mb_reg    <= '0;
      neg_reg   <= 1'b0;
      sa_reg    <= 1'b0;
      cnt_reg   <= '0;
      p_reg     <= '0;
      res_reg   <= '0;
      c_reg     <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      ma_reg    <= ma_next;
      mb_reg    <= mb_next;
      neg_reg   <= neg_next;
      sa_reg    <= sa_next;
      cnt_reg   <= cnt_next;
      p_reg     <= p_next;
      res_reg   <= res_next;
      // Commit only on an unflushed FIN, so that a flush leaves C untouched.
      if (state_reg == FIN && !flush) begin
        c_reg <= res_reg;
      end
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == FIN) && !flush;
  // During the done cycle the fresh result is shown. Otherwise C shows the last committed one.
  assign C    = done ? res_reg : c_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter -- self-checking bench for mdu_iter.
// Directed cases cover the listed operand patterns, flush, reset and start
// handling. They are followed by randomized operations. All of them are
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] C;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .C     (C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on sign- or zero-extended operands.
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin xa = {{32{a[31]}}, a}; xb = {{32{b[31]}}, b}; p = xa * xb; return p[63:32]; end
      3'b010: begin xa = {{32{a[31]}}, a}; xb = {32'd0, b};       p = xa * xb; return p[63:32]; end
      3'b011: begin xa = {32'd0, a};       xb = {32'd0, b};       p = xa * xb; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!o[2]) return 2;
`endif
    return 33;
  endfunction

  // Called at a negedge with the DUT idle. Returns at the negedge of the cycle
  // after done, so the next call issues its start back-to-back.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int  lat, k;
    bit  busy_bad, got_done;
    exp = ref_mdu(o, a, b);
    lat = ref_lat(o, a, b);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0; busy_bad = 0; got_done = 0;
    while (!got_done && k < 100) begin
      @(negedge clk);
      k++;
      if (busy !== 1'b1) busy_bad = 1;
      if (done === 1'b1) got_done = 1;
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " busy"}, {31'd0, busy_bad}, 32'd0);
    check({tag, " C"}, C, exp);
    $display("[TB] %s op=%0d A=0x%08h B=0x%08h C=0x%08h exp=0x%08h lat=%0d", tag, o, a, b, C, exp, k);
    @(negedge clk);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    check({tag, " pulse"}, {31'd0, done}, 32'd0);
    check({tag, " hold"}, C, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  d_op [13];
    logic [31:0] d_a  [13];
    logic [31:0] d_b  [13];
    logic [31:0] prev_c;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int n_done, first_done;
    bit seen, bad;

    d_op = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101,
             3'b100, 3'b111, 3'b100, 3'b110, 3'b000, 3'b111};
    d_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100};
    d_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
             32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset C", C, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed patterns, issued back-to-back
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i]);
    end

    // Flush in cycle t+10 of a DIVU
    prev_c = C;
    op = 3'b101; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      if (k == 10) flush = 1'b1;
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush C", C, prev_c);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check("flush no done", {31'd0, seen}, 32'd0);
    $display("[TB] flush DIVU 100/7 busy=%0d C=0x%08h done_seen=%0d", busy, C, seen);
    run_op("post-flush divu", 3'b101, 32'd100, 32'd7);
    run_op("post-flush remu", 3'b111, 32'd100, 32'd7);

    // Asynchronous reset in the middle of a MUL
    op = 3'b000; A = 32'd7; B = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid-reset busy", {31'd0, busy}, 32'd0);
    check("mid-reset done", {31'd0, done}, 32'd0);
    check("mid-reset C", C, 32'd0);
    @(negedge clk); rstn = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1;
    end
    check("post-reset idle", {31'd0, bad}, 32'd0);
    $display("[TB] reset mid-MUL busy=%0d done=%0d C=0x%08h", busy, done, C);
    run_op("post-reset mul", 3'b000, 32'd7, 32'hFFFF_FFFD);

    // start held high through busy and through FIN: exactly one done
    op = 3'b101; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    n_done = 0; first_done = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = k;
        check("held C", C, 32'd14);
        @(posedge clk); #1 start = 1'b0;
      end
    end
    start = 1'b0;
    check("held done count", 32'(n_done), 32'd1);
    check("held latency", 32'(first_done), 32'd33);
    check("held idle", {31'd0, busy}, 32'd0);
    $display("[TB] held start DIVU 100/7 dones=%0d first=%0d C=0x%08h", n_done, first_done, C);

    // Randomized operations, with the divide special cases mixed in
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 9))
        0: r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: r_b = $urandom_range(1, 15);
        3: r_a = $urandom_range(0, 255);
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), r_op, r_a, r_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
